reverse_cfg_master: RTL and testbench
=====================================

REVERSE_CFG_MASTER -- requirements
Module: reverse_cfg_master

Interface
REQ-001 Parameter POLL_GAP, default 4, idle cycles between consecutive DONE reads.
REQ-002 Parameter TIMEOUT_POLLS, default 65535, maximum DONE reads per job before abort.
REQ-003 Ports (name, direction, width, meaning):
- axi_clk  in  1  sole clock, all logic on rising edge
- axi_rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when high with cmd_valid
- cmd_ori_base  in  64  source byte address
- cmd_bs_base  in  64  destination byte address
- cmd_len  in  32  byte count
- cmpl_valid  out  1  job completion
- cmpl_ready  in  1  completion consumed
- cmpl_status  out  2  0 OK, 1 ZERO_LEN, 2 TIMEOUT
- busy  out  1  job in progress
- reg_wr  out  1  register write request
- reg_rd  out  1  register read request
- reg_addr  out  8  register byte address
- reg_wdata  out  32  write data
- reg_rdata  in  32  read data, valid with reg_ack
- reg_ack  in  1  one-cycle completion of the outstanding access

Function
REQ-004 The block is the initiator that programs and monitors the reverse engine's register responder: ORI_BASE_LOW 0x00, ORI_BASE_HIGH 0x04, BS_BASE_LOW 0x08, BS_BASE_HIGH 0x0C, LEN 0x10, START 0x14, DONE 0x18 (bit 0).
REQ-005 cmd_ready is high only in IDLE; accepting a job captures all cmd fields and moves to the next state on the following edge.
REQ-006 States: IDLE, WR_ORI_L, WR_ORI_H, WR_BS_L, WR_BS_H, WR_LEN, WR_START, WR_UNSTART, POLL_LO, POLL_HI, GAP, CMPL.
REQ-007 Each WR_* state asserts reg_wr with a stable addr/wdata until reg_ack, then advances one state; WR_START writes 1 and WR_UNSTART writes 0 to START.
REQ-008 POLL_LO repeats DONE reads (separated by GAP of POLL_GAP cycles) until bit 0 reads 0; POLL_HI then repeats DONE reads until bit 0 reads 1, then enters CMPL with status OK.
REQ-009 At most one access is outstanding; reg_wr and reg_rd are never high together; a request holds until reg_ack.
REQ-010 reg_ack while no request is pending is ignored.
REQ-011 cmd_len == 0: no bus traffic, go straight to CMPL with status ZERO_LEN.
REQ-012 CMPL holds cmpl_valid and cmpl_status stable until cmpl_ready; returns to IDLE the next cycle; a new cmd is accepted no earlier than that IDLE cycle.
REQ-013 busy is high in every state except IDLE.
REQ-014 Write latency: the first reg_wr is asserted in the cycle after cmd acceptance.

Reset
REQ-015 On axi_rstn low, asynchronously: state IDLE, cmd_ready 1 after reset release, cmpl_valid 0, cmpl_status 0, busy 0, reg_wr 0, reg_rd 0, reg_addr 0, reg_wdata 0, all counters 0.
REQ-016 Reset mid-job abandons it with no completion; any reg_ack arriving after release is ignored.

Configuration
REQ-017 REVERSE_CFG_TIMEOUT_EN defined: a poll counter (reset at WR_UNSTART exit) counts DONE reads across POLL_LO/POLL_HI; reaching TIMEOUT_POLLS without finishing enters CMPL with status TIMEOUT.
REQ-018 REVERSE_CFG_TIMEOUT_EN undefined: no counter; polling continues indefinitely; status TIMEOUT is never produced.

Structure
REQ-019 Register offsets, the state encoding and the status codes live in a shared package, reverse_pkg, used also by the responder.
REQ-020 One sub-module, reverse_cfg_bus_req, owns the single-outstanding request/ack handshake.

Verification
REQ-021 ori 0, bs 2048, len 2048, responder acks in 1 cycle -> writes 0x00=0, 0x04=0, 0x08=2048, 0x0C=0, 0x10=2048, 0x14=1, 0x14=0 in order; DONE reads 1,0,0,1 -> cmpl OK.
REQ-022 len 0 -> no reg_wr/reg_rd ever; cmpl_valid with ZERO_LEN one cycle after acceptance.
REQ-023 Ack delayed 7 cycles per access -> addr/wdata stable across all 7 cycles; same write sequence as REQ-021.
REQ-024 With REVERSE_CFG_TIMEOUT_EN, TIMEOUT_POLLS 8, DONE stuck 0 -> exactly 8 DONE reads, then cmpl TIMEOUT.
REQ-025 cmpl_ready held low 20 cycles -> cmpl_valid/status stable; second cmd_valid not accepted until after the handshake.
REQ-026 axi_rstn pulsed during POLL_HI -> all outputs at reset values immediately; next job runs normally.

Source files
------------

// File: rtl/reverse_pkg.sv
// rtl/reverse_pkg.sv - register map, FSM states and completion codes shared by the reverse engine master and responder
package reverse_pkg;

   localparam logic [7:0] REG_ORI_BASE_LOW  = 8'h00;
   localparam logic [7:0] REG_ORI_BASE_HIGH = 8'h04;
   localparam logic [7:0] REG_BS_BASE_LOW   = 8'h08;
   localparam logic [7:0] REG_BS_BASE_HIGH  = 8'h0C;
   localparam logic [7:0] REG_LEN           = 8'h10;
   localparam logic [7:0] REG_START         = 8'h14;
   localparam logic [7:0] REG_DONE          = 8'h18;

   typedef enum logic [3:0] {
      IDLE,
      WR_ORI_L,
      WR_ORI_H,
      WR_BS_L,
      WR_BS_H,
      WR_LEN,
      WR_START,
      WR_UNSTART,
      POLL_LO,
      POLL_HI,
      GAP,
      CMPL
   } state_t;

   typedef enum logic [1:0] {
      CMPL_OK       = 2'd0,
      CMPL_ZERO_LEN = 2'd1,
      CMPL_TIMEOUT  = 2'd2
   } status_t;

   function automatic logic is_access(input state_t s);
      case (s)
         WR_ORI_L, WR_ORI_H, WR_BS_L, WR_BS_H, WR_LEN,
         WR_START, WR_UNSTART, POLL_LO, POLL_HI: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] reg_addr_of(input state_t s);
      case (s)
         WR_ORI_L:            return REG_ORI_BASE_LOW;
         WR_ORI_H:            return REG_ORI_BASE_HIGH;
         WR_BS_L:             return REG_BS_BASE_LOW;
         WR_BS_H:             return REG_BS_BASE_HIGH;
         WR_LEN:              return REG_LEN;
         WR_START, WR_UNSTART: return REG_START;
         POLL_LO, POLL_HI:    return REG_DONE;
         default:             return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/reverse_cfg_bus_req.sv
// rtl/reverse_cfg_bus_req.sv - single-outstanding register request holder; launches on issue, retires on reg_ack
module reverse_cfg_bus_req (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue,
   input  logic        issue_wr,
   input  logic [7:0]  issue_addr,
   input  logic [31:0] issue_wdata,
   input  logic        reg_ack,
   output logic        done,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [7:0]  reg_addr,
   output logic [31:0] reg_wdata
);

   // An ack with nothing outstanding never reaches the FSM.
   assign done = reg_ack && (reg_wr || reg_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 32'h0;
      end else if (issue) begin
         reg_wr    <= issue_wr;
         reg_rd    <= !issue_wr;
         reg_addr  <= issue_addr;
         reg_wdata <= issue_wr ? issue_wdata : 32'h0;
      end else if (done) begin
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
      end
   end

endmodule

// File: rtl/reverse_cfg_master.sv
// rtl/reverse_cfg_master.sv - programs the reverse engine registers, pulses START and polls DONE for one job at a time
// REVERSE_CFG_TIMEOUT_EN adds a DONE-read limit of TIMEOUT_POLLS that completes the job with status TIMEOUT.
module reverse_cfg_master
   import reverse_pkg::*;
#(
   parameter int POLL_GAP      = 4,
   parameter int TIMEOUT_POLLS = 65535
) (
   input  logic        axi_clk,
   input  logic        axi_rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_ori_base,
   input  logic [63:0] cmd_bs_base,
   input  logic [31:0] cmd_len,
   output logic        cmpl_valid,
   input  logic        cmpl_ready,
   output logic [1:0]  cmpl_status,
   output logic        busy,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [7:0]  reg_addr,
   output logic [31:0] reg_wdata,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   state_t        state;
   state_t        state_next;
   status_t       status_q;
   status_t       status_next;
   logic [31:0]   ori_hi_q;
   logic [63:0]   bs_q;
   logic [31:0]   len_q;
   logic          phase_hi_q;
   logic          phase_hi_next;
   logic [GW-1:0] gap_cnt;
   logic          accept;
   logic          done;
   logic          timeout_hit;
   logic          issue;
   logic          issue_wr;
   logic [7:0]    issue_addr;
   logic [31:0]   issue_wdata;
   logic          unused_rdata;

   assign accept       = cmd_valid && (state == IDLE);
   assign cmd_ready    = (state == IDLE);
   assign busy         = (state != IDLE);
   assign cmpl_valid   = (state == CMPL);
   assign cmpl_status  = status_q;
   assign unused_rdata = ^reg_rdata[31:1];

`ifdef REVERSE_CFG_TIMEOUT_EN
   localparam int PW = $clog2(TIMEOUT_POLLS + 1);
   logic [PW-1:0] poll_cnt;

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         poll_cnt <= '0;
      end else if (state == WR_UNSTART && done) begin
         poll_cnt <= '0;
      end else if ((state == POLL_LO || state == POLL_HI) && done) begin
         poll_cnt <= poll_cnt + 1'b1;
      end
   end

   // Evaluated on the completing read, so this read is the last one allowed.
   assign timeout_hit = (poll_cnt == PW'(TIMEOUT_POLLS - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge axi_clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
         state      <= IDLE;
         status_q   <= CMPL_OK;
         ori_hi_q   <= 32'h0;
         bs_q       <= 64'h0;
         len_q      <= 32'h0;
         phase_hi_q <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_next;
         status_q   <= status_next;
         phase_hi_q <= phase_hi_next;
         gap_cnt    <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (accept) begin
            ori_hi_q <= cmd_ori_base[63:32];
            bs_q     <= cmd_bs_base;
            len_q    <= cmd_len;
         end
      end
   end

   always_comb begin
      state_next    = state;
      status_next   = status_q;
      phase_hi_next = phase_hi_q;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == 32'd0) begin
                  state_next  = CMPL;
                  status_next = CMPL_ZERO_LEN;
               end else begin
                  state_next    = WR_ORI_L;
                  phase_hi_next = 1'b0;
               end
            end
         end
         WR_ORI_L:   if (done) state_next = WR_ORI_H;
         WR_ORI_H:   if (done) state_next = WR_BS_L;
         WR_BS_L:    if (done) state_next = WR_BS_H;
         WR_BS_H:    if (done) state_next = WR_LEN;
         WR_LEN:     if (done) state_next = WR_START;
         WR_START:   if (done) state_next = WR_UNSTART;
         WR_UNSTART: if (done) state_next = POLL_LO;
         POLL_LO, POLL_HI: begin
            if (done) begin
               if (state == POLL_HI && reg_rdata[0]) begin
                  state_next  = CMPL;
                  status_next = CMPL_OK;
               end else if (timeout_hit) begin
                  state_next  = CMPL;
                  status_next = CMPL_TIMEOUT;
               end else begin
                  phase_hi_next = (state == POLL_HI) || !reg_rdata[0];
                  state_next    = (POLL_GAP == 0) ? (phase_hi_next ? POLL_HI : POLL_LO) : GAP;
               end
            end
         end
         GAP:  if (gap_cnt == GAP_LAST) state_next = phase_hi_q ? POLL_HI : POLL_LO;
         CMPL: if (cmpl_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Requests are launched on the edge that enters an access state, so the
   // bus sees the next access in the cycle right after the previous ack.
   always_comb begin
      issue      = is_access(state_next) && ((state_next != state) || done);
      issue_wr   = (state_next != POLL_LO) && (state_next != POLL_HI);
      issue_addr = reg_addr_of(state_next);
      case (state_next)
         WR_ORI_L: issue_wdata = cmd_ori_base[31:0];
         WR_ORI_H: issue_wdata = ori_hi_q;
         WR_BS_L:  issue_wdata = bs_q[31:0];
         WR_BS_H:  issue_wdata = bs_q[63:32];
         WR_LEN:   issue_wdata = len_q;
         WR_START: issue_wdata = 32'd1;
         default:  issue_wdata = 32'd0;
      endcase
   end

   reverse_cfg_bus_req u_bus_req (
      .clk         (axi_clk),
      .rst_n       (axi_rstn),
      .issue       (issue),
      .issue_wr    (issue_wr),
      .issue_addr  (issue_addr),
      .issue_wdata (issue_wdata),
      .reg_ack     (reg_ack),
      .done        (done),
      .reg_wr      (reg_wr),
      .reg_rd      (reg_rd),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata)
   );

endmodule

// File: tb/tb_reverse_cfg_master.sv
// tb/tb_reverse_cfg_master.sv - directed and randomized jobs against a register responder and a job-level reference model
module tb_reverse_cfg_master;

   localparam int TB_GAP = 3;
   localparam int TB_TO  = 8;
`ifdef REVERSE_CFG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        axi_clk;
   logic        axi_rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_ori_base;
   logic [63:0] cmd_bs_base;
   logic [31:0] cmd_len;
   logic        cmpl_valid;
   logic        cmpl_ready;
   logic [1:0]  cmpl_status;
   logic        busy;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   int          ack_delay = 1;
   bit          done_q[$];
   bit          job_seq[$];
   bit          exp_rd[$];
   bit          log_wr[$];
   logic [7:0]  log_addr[$];
   logic [31:0] log_data[$];
   int          log_idle[$];
   int          stab_err = 0;
   int          both_err = 0;
   bit          spurious = 1'b0;

   reverse_cfg_master #(.POLL_GAP(TB_GAP), .TIMEOUT_POLLS(TB_TO)) dut (
      .axi_clk      (axi_clk),
      .axi_rstn     (axi_rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_ori_base (cmd_ori_base),
      .cmd_bs_base  (cmd_bs_base),
      .cmd_len      (cmd_len),
      .cmpl_valid   (cmpl_valid),
      .cmpl_ready   (cmpl_ready),
      .cmpl_status  (cmpl_status),
      .busy         (busy),
      .reg_wr       (reg_wr),
      .reg_rd       (reg_rd),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_rdata    (reg_rdata),
      .reg_ack      (reg_ack)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Responder: acks each access ack_delay cycles after it is first seen and logs it.
   initial begin
      bit          was_ack;
      bit          in_acc;
      int          wait_cnt;
      int          idle_run;
      logic [7:0]  cap_addr;
      logic [31:0] cap_data;
      logic        cap_wr;
      logic [31:0] rd;
      bit          v;
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      in_acc    = 1'b0;
      wait_cnt  = 0;
      idle_run  = 0;
      cap_addr  = 8'h0;
      cap_data  = 32'h0;
      cap_wr    = 1'b0;
      forever begin
         @(negedge axi_clk);
         if (!axi_rstn) begin
            reg_ack  = 1'b0;
            in_acc   = 1'b0;
            wait_cnt = 0;
         end else begin
            was_ack = reg_ack;
            reg_ack = 1'b0;
            if (reg_wr && reg_rd) both_err++;
            if (!(reg_wr || reg_rd)) begin
               idle_run++;
               in_acc = 1'b0;
               if (spurious && !was_ack) begin
                  reg_ack  = 1'b1;
                  spurious = 1'b0;
               end
            end else if (!was_ack) begin
               if (!in_acc) begin
                  in_acc   = 1'b1;
                  cap_addr = reg_addr;
                  cap_data = reg_wdata;
                  cap_wr   = reg_wr;
                  wait_cnt = 0;
                  log_idle.push_back(idle_run);
                  idle_run = 0;
               end else if (reg_addr !== cap_addr || reg_wdata !== cap_data || reg_wr !== cap_wr) begin
                  stab_err++;
               end
               if (wait_cnt >= ack_delay - 1) begin
                  reg_ack = 1'b1;
                  in_acc  = 1'b0;
                  log_wr.push_back(reg_wr);
                  log_addr.push_back(reg_addr);
                  if (reg_wr) begin
                     log_data.push_back(reg_wdata);
                  end else begin
                     v = (done_q.size() > 0) ? done_q.pop_front() : 1'b0;
                     rd = $urandom;
                     rd[0] = v;
                     reg_rdata = rd;
                     log_data.push_back({31'd0, v});
                  end
               end else begin
                  wait_cnt++;
               end
            end
         end
      end
   end

   function automatic int rd_count();
      int n = 0;
      foreach (log_wr[i]) if (!log_wr[i]) n++;
      return n;
   endfunction

   // Job-level model of the DONE handshake: wait for 0, then for 1, optionally capped.
   task automatic model_reads(output int n, output logic [1:0] st);
      bit hi = 1'b0;
      bit v;
      n  = 0;
      st = 2'd0;
      exp_rd.delete();
      while (n < 1000) begin
         v = (n < job_seq.size()) ? job_seq[n] : 1'b0;
         n++;
         exp_rd.push_back(v);
         if (hi && v) begin
            st = 2'd0;
            break;
         end
         if (TO_EN && n == TB_TO) begin
            st = 2'd2;
            break;
         end
         if (!v) hi = 1'b1;
      end
   endtask

   task automatic start_job(input logic [63:0] ori, input logic [63:0] bs, input logic [31:0] len);
      @(posedge axi_clk);
      #1;
      log_wr.delete();
      log_addr.delete();
      log_data.delete();
      log_idle.delete();
      stab_err = 0;
      both_err = 0;
      @(negedge axi_clk);
      cmd_ori_base = ori;
      cmd_bs_base  = bs;
      cmd_len      = len;
      cmd_valid    = 1'b1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      @(negedge axi_clk);
      cmd_valid = 1'b0;
      if (len == 32'd0) begin
         chk("zero_len_cmpl", {61'd0, cmpl_valid, cmpl_status}, {61'd0, 1'b1, 2'd1});
         chk("zero_len_no_req", {62'd0, reg_wr, reg_rd}, 64'd0);
      end else begin
         chk("first_wr_latency", {22'd0, reg_wr, reg_rd, reg_addr, reg_wdata},
             {22'd0, 1'b1, 1'b0, 8'h00, ori[31:0]});
         chk("busy_in_job", 64'(busy), 64'd1);
      end
   endtask

   task automatic finish_job(input logic [1:0] exp_st, input int hold, input bit hold_cmd);
      int n = 0;
      while (cmpl_valid !== 1'b1 && n < 4000) begin
         @(negedge axi_clk);
         n++;
      end
      chk("cmpl_within_budget", 64'(cmpl_valid), 64'd1);
      chk("cmpl_status", 64'(cmpl_status), 64'(exp_st));
      cmd_valid = hold_cmd;
      for (int i = 0; i < hold; i++) begin
         @(negedge axi_clk);
         chk("cmpl_hold", {61'd0, cmpl_valid, cmpl_status}, {61'd0, 1'b1, exp_st});
         if (hold_cmd) chk("no_accept_during_cmpl", 64'(cmd_ready), 64'd0);
      end
      cmd_valid  = 1'b0;
      cmpl_ready = 1'b1;
      @(negedge axi_clk);
      cmpl_ready = 1'b0;
      chk("cmpl_released", {62'd0, cmpl_valid, cmd_ready}, {62'd0, 1'b0, 1'b1});
   endtask

   task automatic check_job(input logic [63:0] ori, input logic [63:0] bs, input logic [31:0] len, input int nrd);
      bit          ew[$];
      logic [7:0]  ea[$];
      logic [31:0] ed[$];
      int          m;
      if (len != 32'd0) begin
         ew = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
         ea = {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h14};
         ed = {ori[31:0], ori[63:32], bs[31:0], bs[63:32], len, 32'd1, 32'd0};
         for (int i = 0; i < nrd; i++) begin
            ew.push_back(1'b0);
            ea.push_back(8'h18);
            ed.push_back({31'd0, exp_rd[i]});
         end
      end
      chk("access_count", 64'(log_addr.size()), 64'(ea.size()));
      m = (log_addr.size() < ea.size()) ? log_addr.size() : ea.size();
      for (int i = 0; i < m; i++)
         chk($sformatf("access[%0d]", i), {23'd0, log_wr[i], log_addr[i], log_data[i]},
             {23'd0, ew[i], ea[i], ed[i]});
      for (int i = 8; i < m; i++)
         chk($sformatf("poll_gap[%0d]", i), 64'(log_idle[i]), 64'(TB_GAP));
      chk("req_stable", 64'(stab_err), 64'd0);
      chk("no_wr_rd_overlap", 64'(both_err), 64'd0);
   endtask

   task automatic run_job(input logic [63:0] ori, input logic [63:0] bs, input logic [31:0] len,
                          input int delay, input int hold, input bit hold_cmd);
      int         nrd;
      logic [1:0] st;
      if (len == 32'd0) begin
         nrd = 0;
         st  = 2'd1;
         exp_rd.delete();
      end else begin
         model_reads(nrd, st);
      end
      ack_delay = delay;
      done_q    = job_seq;
      start_job(ori, bs, len);
      finish_job(st, hold, hold_cmd);
      check_job(ori, bs, len, nrd);
   endtask

   task automatic random_seq();
      job_seq.delete();
      repeat ($urandom_range(0, 2)) job_seq.push_back(1'b1);
      job_seq.push_back(1'b0);
      repeat ($urandom_range(0, 2)) job_seq.push_back(1'b0);
      job_seq.push_back(1'b1);
   endtask

   initial begin
      int n;
      axi_rstn     = 1'b0;
      cmd_valid    = 1'b0;
      cmd_ori_base = 64'h0;
      cmd_bs_base  = 64'h0;
      cmd_len      = 32'h0;
      cmpl_ready   = 1'b0;
      repeat (3) @(negedge axi_clk);
      chk("in_reset_bus", {22'd0, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);
      #2 axi_rstn = 1'b1;
      @(negedge axi_clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cmpl", {61'd0, cmpl_valid, cmpl_status}, 64'd0);
      chk("rst_bus", {22'd0, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);

      job_seq = {1'b1, 1'b0, 1'b0, 1'b1};
      run_job(64'd0, 64'd2048, 32'd2048, 1, 0, 1'b0);

      job_seq.delete();
      run_job(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 32'd0, 1, 0, 1'b0);

      job_seq = {1'b1, 1'b0, 1'b0, 1'b1};
      run_job(64'd0, 64'd2048, 32'd2048, 7, 0, 1'b0);

      random_seq();
      run_job({$urandom, $urandom}, {$urandom, $urandom}, 32'd4096, 2, 20, 1'b1);

      for (int k = 0; k < 6; k++) begin
         random_seq();
         run_job({$urandom, $urandom}, {$urandom, $urandom}, 32'($urandom_range(1, 65535)),
                 $urandom_range(1, 4), $urandom_range(0, 3), 1'b0);
      end

`ifdef REVERSE_CFG_TIMEOUT_EN
      job_seq.delete();
      run_job(64'h10, 64'h20, 32'd64, 1, 0, 1'b0);
`endif

      job_seq.delete();
      run_job(64'h5, 64'h6, 32'd0, 1, 0, 1'b0);

      job_seq = {1'b0};
      ack_delay = 1;
      done_q    = job_seq;
      start_job(64'hAAAA_0000_BBBB_1111, 64'hCCCC_2222_DDDD_3333, 32'd512);
      n = 0;
      while (rd_count() < 2 && n < 500) begin
         @(negedge axi_clk);
         n++;
      end
      chk("reached_poll_hi", 64'(rd_count() >= 2), 64'd1);
      #2 axi_rstn = 1'b0;
      #1;
      chk("midjob_rst_busy", 64'(busy), 64'd0);
      chk("midjob_rst_cmpl", {61'd0, cmpl_valid, cmpl_status}, 64'd0);
      chk("midjob_rst_bus", {22'd0, reg_wr, reg_rd, reg_addr, reg_wdata}, 64'd0);
      repeat (3) @(negedge axi_clk);
      #2 axi_rstn = 1'b1;
      spurious = 1'b1;
      repeat (4) @(negedge axi_clk);
      chk("post_rst_idle", {60'd0, cmd_ready, busy, cmpl_valid, reg_wr | reg_rd},
          {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});

      job_seq = {1'b0, 1'b1};
      run_job(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 32'd100, 1, 0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
